data_memory: RTL and testbench
==============================

# data_memory

Off-chip main memory model behind the CPU data cache: 512 lines × 256 bits (16 KB), accessed one full cache line at a time. A request is accepted on `enable_i`, takes a fixed multi-cycle latency, and completes with a single-cycle `ack_o` pulse. Read data is presented with the ack, and writes commit on the ack edge. It sits on the cache-to-memory port of the CPU top level, and the testbench can preload or flush it hierarchically.

## Interface
- `MEM_LATENCY`, default 10: number of WAIT cycles per transaction, counting the ack cycle. Legal range is 2..16.
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous, active-low reset.
- `addr_i` input 32: byte address. The line index is `addr_i[13:5]`; bits [4:0] and [31:14] are ignored.
- `data_i` input 256: write line.
- `enable_i` input 1: request valid.
- `write_i` input 1: 1 = write, 0 = read.
- `ack_o` output 1: transaction-complete pulse, one cycle wide.
- `data_o` output 256: read line.
- Internal, hierarchically visible names: `memory[0:511]` (256-bit), `data` (256-bit), `count` (4-bit), `state` (1-bit).

## Operation
- States:
  - IDLE = 0.
  - WAIT = 1.
- IDLE:
  - `enable_i`=1 at an edge moves to WAIT with `count`=0.
  - Otherwise stay in IDLE with `count`=0.
- WAIT:
  - `count` increments each edge.
  - When `count`==`MEM_LATENCY`-1 at an edge, go to IDLE with `count`=0.
- `ack_o` = (state==WAIT) && (`count`==`MEM_LATENCY`-1). It is combinational from state.
- Read path: at the edge where `count` goes from `MEM_LATENCY`-2 to `MEM_LATENCY`-1, load `data` ← `memory[addr_i[13:5]]`.
- `data_o` = `data`, held until the next read load.
- Write path: at the edge where `ack_o`=1 and `write_i`=1, `memory[addr_i[13:5]]` ← `data_i`. `data` is still loaded with the old line but is not meaningful for writes.
- The requester holds `addr_i`, `data_i` and `write_i` stable from acceptance through the ack cycle.
- Dropping `enable_i` after acceptance does not cancel the transaction; it completes and acks.
- `enable_i` sampled during WAIT is ignored; there is no queuing.
- Memory contents are not cleared by reset.

## Timing
- Reset (`rst_i`=0 at an edge):
  - `state`=IDLE, `count`=0, `data`=0.
  - Resulting outputs: `ack_o`=0, `data_o`=0.
- Acceptance edge E0 is the edge with IDLE and `enable_i`=1.
- Ack is high during the cycle following edge E0+(`MEM_LATENCY`-1): exactly one cycle, `MEM_LATENCY` cycles after E0.
- The write commits at edge E0+`MEM_LATENCY`.
- Back-to-back requests:
  - The earliest next acceptance is edge E0+`MEM_LATENCY`+1.
  - There is a mandatory single IDLE cycle between transactions.
- Reset during WAIT aborts the transaction: no ack and no write.
- Address wrap: bits above 13 are ignored, so 0x4000 aliases line 0.

## Configuration
- `DMEM_TRACE_EN` defined:
  - On every ack edge, print one simulation line with the time, R or W, the index, and the 256-bit line (data written, or data read).
  - The trace code is excluded from synthesis.
- `DMEM_TRACE_EN` undefined: no trace code is compiled; behaviour is otherwise identical.

## Test plan
- Reset, then read:
  - Preload `memory[0]`=0x0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF.
  - Read `addr_i`=0x0000 → `ack_o` high for exactly one cycle, 10 cycles after acceptance, with `data_o` equal to that line.
- Read `addr_i`=0x0220:
  - `memory[17]`=0x0000_0110_…_0FF0.
  - Expect `data_o`=that line, and `ack_o`=0 in all other cycles.
- Write then read back:
  - Write 0xECFA repeated ×16 to 0x0240, and check `memory[18]` updates at the ack edge, not before.
  - A subsequent read of 0x0240 returns 0xECFA repeated ×16.
- Offset and alias:
  - Read 0x001F → line 0.
  - Read 0x4000 → line 0.
  - Write to 0x4020 → modifies `memory[1]`.
- Handshake edges:
  - Drop `enable_i` one cycle after acceptance → ack still occurs at cycle 10.
  - Hold `enable_i` high continuously → acks spaced 11 cycles apart.
- Reset mid-operation:
  - Assert `rst_i`=0 at WAIT `count`=5 of a write → no ack and `memory` unchanged.
  - After reset: `state`=0, `count`=0, `data_o`=0.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: line-wide (256-bit) main memory model behind the data cache.
// 512 lines, fixed MEM_LATENCY-cycle access, single-cycle ack_o pulse.
// Optional macro DMEM_TRACE_EN: prints one line per completed transaction.
`timescale 1ns/1ps
module data_memory #(
  parameter int unsigned MEM_LATENCY = 10  // WAIT cycles incl. ack cycle, 2..16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] PRE  = 4'(MEM_LATENCY - 2);

  // names kept plain so the bench and the CPU top can reach them hierarchically
  logic [255:0] memory [0:511];
  logic [255:0] data;
  logic [3:0]   count;
  state_t       state;

  state_t       w_state_nxt;
  logic [3:0]   w_count_nxt;
  logic [8:0]   w_idx;
  logic         w_ack;
  logic         w_load;
  logic         w_unused;

  assign w_idx    = addr_i[13:5];
  assign w_unused = ^{addr_i[31:14], addr_i[4:0]};
  assign w_ack    = (state == WAIT) && (count == LAST);
  // read line is fetched one edge early so it is stable during the ack cycle
  assign w_load   = (state == WAIT) && (count == PRE);
  assign ack_o    = w_ack;
  assign data_o   = data;

  // next-state / counter logic; enable_i is ignored while busy
  always_comb begin
    w_state_nxt = state;
    w_count_nxt = '0;
    case (state)
      IDLE: if (enable_i) w_state_nxt = WAIT;
      WAIT: begin
        if (count == LAST) w_state_nxt = IDLE;
        else               w_count_nxt = count + 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, counter and read-data registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
      data  <= '0;
    end else begin
      state <= w_state_nxt;
      count <= w_count_nxt;
      if (w_load) data <= memory[w_idx];
    end
  end

  // line write commits on the ack edge; a reset on that edge suppresses it
  always_ff @(posedge clk_i) begin
    if (rst_i && w_ack && write_i) memory[w_idx] <= data_i;
  end

`ifdef DMEM_TRACE_EN
  // transaction trace, simulation only
  always_ff @(posedge clk_i) begin
    if (rst_i && w_ack)
      $display("%0t dmem %s idx=%0d line=%h", $time, write_i ? "W" : "R",
               w_idx, write_i ? data_i : data);
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: table-driven vectors plus hand sequences for data_memory.
`timescale 1ns/1ps
module tb_data_memory;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         en;
  logic         wr;
  logic         ack;
  logic [255:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [255:0] sb[$];

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic [255:0] exp;
    logic         chk_old;
    logic [255:0] old;
  } vec_t;

  vec_t tv[13];

  data_memory #(.MEM_LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
    .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic on_ack(input string name);
    if (sb.size() == 0) chk({name, "_unexpected_ack"}, 256'd1, 256'd0);
    else chk(name, rdata, sb.pop_front());
  endtask

  // one transaction from IDLE; drop=1 releases enable right after acceptance
  task automatic run_txn(input vec_t v, input bit drop, input string name);
    int nacks = 0;
    int ack_k = -1;
    logic [8:0] idx = v.addr[13:5];
    @(negedge clk);
    en = 1'b1; wr = v.wr; addr = v.addr; wdata = v.wd;
    if (!v.wr) sb.push_back(v.exp);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack) begin
        nacks++;
        ack_k = k;
        if (!v.wr) on_ack({name, "_rdata"});
        else if (v.chk_old) chk({name, "_mem_before_ack_edge"}, dut.memory[idx], v.old);
      end
      if (v.wr && k == 11) chk({name, "_mem_after_ack_edge"}, dut.memory[idx], v.wd);
      if ((drop && k == 1) || k == 10) en = 1'b0;
    end
    chk({name, "_ack_once_at_10"}, 256'({nacks, ack_k}), 256'({32'd1, 32'd10}));
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ack) on_ack("drain_rdata");
    end
  endtask

  logic [255:0] p0, p17, pe, p18o, pa, pb, pc, pd;

  initial begin
    p0   = 256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
    for (int i = 0; i < 16; i++) p17[255-16*i -: 16] = 16'(i * 16'h0110);
    pe   = {16{16'hECFA}};
    p18o = {8{32'h12345678}};
    pa   = {8{32'hA5A5_0001}};
    pb   = {8{32'h5A5A_0002}};
    pc   = {8{32'hC0DE_0005}};
    pd   = {8{32'hDEAD_BEEF}};

    //        wr    addr          wd     exp   chk_old old
    tv[0]  = '{1'b1, 32'h0000_0000, p0,   '0,  1'b0, '0};
    tv[1]  = '{1'b1, 32'h0000_0220, p17,  '0,  1'b0, '0};
    tv[2]  = '{1'b1, 32'h0000_0240, p18o, '0,  1'b0, '0};
    tv[3]  = '{1'b0, 32'h0000_0000, '0,   p0,  1'b0, '0};
    tv[4]  = '{1'b0, 32'h0000_0220, '0,   p17, 1'b0, '0};
    tv[5]  = '{1'b1, 32'h0000_0240, pe,   '0,  1'b1, p18o};
    tv[6]  = '{1'b0, 32'h0000_0240, '0,   pe,  1'b0, '0};
    tv[7]  = '{1'b0, 32'h0000_001F, '0,   p0,  1'b0, '0};
    tv[8]  = '{1'b0, 32'h0000_4000, '0,   p0,  1'b0, '0};
    tv[9]  = '{1'b1, 32'h0000_0020, pa,   '0,  1'b0, '0};
    tv[10] = '{1'b1, 32'h0000_4020, pb,   '0,  1'b1, pa};
    tv[11] = '{1'b0, 32'h0000_0020, '0,   pb,  1'b0, '0};
    tv[12] = '{1'b1, 32'h0000_00A0, pc,   '0,  1'b0, '0};

    rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ack", 256'(ack), 256'd0);
    chk("reset_data", rdata, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_txn(tv[i], 1'b0, $sformatf("vec%0d", i));

    // enable dropped right after acceptance still completes
    run_txn(tv[4], 1'b1, "drop_en");

    // enable held high: acks at cycles 10, 21, 32, a fourth request follows
    begin
      int acks[$];
      @(negedge clk);
      en = 1'b1; wr = 1'b0; addr = 32'h0;
      for (int j = 0; j < 4; j++) sb.push_back(p0);
      for (int c = 1; c <= 35; c++) begin
        @(negedge clk);
        if (ack) begin
          acks.push_back(c);
          on_ack("b2b_rdata");
        end
      end
      en = 1'b0;
      chk("b2b_ack_count", 256'(acks.size()), 256'd3);
      if (acks.size() == 3) begin
        chk("b2b_first", 256'(acks[0]), 256'd10);
        chk("b2b_gap1", 256'(acks[1] - acks[0]), 256'd11);
        chk("b2b_gap2", 256'(acks[2] - acks[1]), 256'd11);
      end
      drain(14);
      chk("b2b_sb_empty", 256'(sb.size()), 256'd0);
    end

    // reset at count=5 of a write aborts it
    begin
      int nacks = 0;
      @(negedge clk);
      en = 1'b1; wr = 1'b1; addr = 32'h0000_00A0; wdata = pd;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (ack) nacks++;
        if (k == 1) en = 1'b0;
      end
      chk("rst_mid_count5", 256'(dut.count), 256'd5);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_state", 256'(dut.state), 256'd0);
      chk("rst_mid_count", 256'(dut.count), 256'd0);
      chk("rst_mid_data", rdata, '0);
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        if (ack) nacks++;
      end
      chk("rst_mid_no_ack", 256'(nacks), 256'd0);
      chk("rst_mid_mem_unchanged", dut.memory[5], pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
